n4by2_b2_div_sequencer: RTL
===========================

Name: n4by2_b2_div_sequencer

Overview:
Shares one n3by2_b2_divider stage between two requesters, A and B, using round-robin arbitration. It sequences each 4-digit / 2-digit base-2 division as two iterative steps. The feasibility check is done at accept time, and infeasible operations skip the datapath. The result is held with a valid/ack handshake until the consumer takes it.

Parameters:
RR_INIT, 0, requester with priority on the first contention after reset (0 = A, 1 = B).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A has an operation pending; held with operands until gnt_a
x_a  input  4  dividend from A (x3_x0)
y_a  input  2  divisor from A (y1_y0)
gnt_a  output  1  combinational; A's operands are captured at this clock edge
req_b  input  1  as req_a, requester B
x_b  input  4  dividend from B
y_b  input  2  divisor from B
gnt_b  output  1  as gnt_a, requester B
out_valid  output  1  result available, held until out_ack
out_id  output  1  requester of the current result (0 = A, 1 = B)
q  output  2  quotient q1_q0, valid when out_valid and no_div = 0
r  output  2  remainder r1_r0, valid when out_valid and no_div = 0
no_div  output  1  operation was infeasible; q and r are forced to 0
out_ack  input  1  consumer accepts the result; sampled only while out_valid

Behaviour:
- States: IDLE, STEP1, STEP2, DONE. Reset puts the FSM in IDLE.
- Reset values: out_valid, out_id, q, r and no_div are 0. Internal operand registers are 0. The priority pointer is RR_INIT.
- Grants in IDLE:
  - gnt_a/gnt_b are asserted only in IDLE, are mutually exclusive and are at most 1 cycle wide.
  - With a single request, that requester is granted.
  - With both requests, the requester named by the pointer is granted. The pointer then toggles to the other requester.
  - A grant with no contention also sets the pointer to the non-granted requester.
- Accept edge: the granted x, y and id are latched. Feasibility is computed on the granted operands: no_div = (y == 0) or (x >= 4*y), using full-width unsigned compare with no truncation.
  - Infeasible: go to DONE. Set q = 0, r = 0, no_div = 1.
  - Feasible: go to STEP1.
- STEP1: the shared stage gets {x[3:1]} and y. Latch q[1] and the partial remainder. Go to STEP2.
- STEP2: the shared stage gets {partial remainder, x[0]} and y. Latch q[0] and r. Go to DONE.
- The stage is the only divider instance. Its inputs are muxed by state, and it is undriven-don't-care in IDLE and DONE.
- DONE: out_valid = 1, and q, r, no_div, out_id are stable.
  - On out_ack = 1, go to IDLE and clear out_valid next cycle. No grant is issued in the ack cycle.
  - Without ack, hold indefinitely. Requests wait and operands are not sampled.
- Latency, with grant in cycle t:
  - Feasible: out_valid first high in t+3.
  - Infeasible: out_valid first high in t+1.
  - Minimum issue interval per operation is 4 cycles feasible, 2 cycles infeasible (ack in the first DONE cycle).
- Arithmetic: unsigned base 2. When feasible, x = 4*q... more precisely x = q*y + r with r < y.
- out_ack outside DONE is ignored.
- req dropped before grant is legal: nothing is captured.
- Reset mid-operation (any state): abort immediately, no out_valid for the aborted operation. The pointer returns to RR_INIT.
- Reset has priority over req/ack in the same cycle: no grant is issued.

Test Plan:
- Single A request, x_a = 7, y_a = 2, ack immediately -> gnt_a at t, out_valid at t+3, q = 3, r = 1, no_div = 0, out_id = 0. out_valid drops at t+4.
- B request, x_b = 11, y_b = 3 -> q = 3, r = 2, out_id = 1. Also x_b = 5, y_b = 3 -> q = 1, r = 2.
- Infeasible cases: x = 8, y = 2 (boundary x = 4y) -> out_valid at t+1, no_div = 1, q = r = 0. Likewise x = 3, y = 0 -> no_div = 1.
- Both requests held continuously with RR_INIT = 0, operations A(7,2) and B(11,3) -> grants alternate A, B, A. out_id sequence is 0, 1, 0. No two grants occur without an intervening DONE + ack.
- Hold/backpressure: out_ack kept 0 for 10 cycles in DONE -> outputs stable, gnt_a/gnt_b stay 0. On ack, IDLE follows and the next grant comes in the cycle after ack.
- Reset asserted in STEP2 -> next cycle IDLE, all outputs 0, no out_valid. The pointer is reinitialised, so a subsequent contention grants A when RR_INIT = 0.

Source files
------------

// File: rtl/n4by2_b2_div_sequencer.sv
// n4by2_b2_div_sequencer
//   Two requesters (A, B) share a single 3-by-2 base-2 divider stage under
//   round-robin arbitration. Each 4-digit / 2-digit division is sequenced as
//   two iterative stage passes (STEP1, STEP2). Infeasible operations are
//   detected when the operands are accepted and bypass the stage entirely.
//   The result is held until the consumer acknowledges it.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_a, x_a, y_a     requester A: request, dividend[3:0], divisor[1:0]
//   gnt_a               combinational grant; A's operands latch at this edge
//   req_b, x_b, y_b     requester B, same meaning as A
//   gnt_b               combinational grant for B
//   out_valid           result held until out_ack
//   out_id              requester that owns the result (0 = A, 1 = B)
//   q, r                quotient / remainder (0 when no_div)
//   no_div              operation infeasible (y == 0 or x >= 4*y)
//   out_ack             consumer takes the result; ignored outside DONE

// Single radix-2 restoring step: 3-bit partial dividend over 2-bit divisor.
// Callers guarantee d < 2*y, so the quotient is one bit and the remainder
// fits in two bits; the 2-bit modular subtract therefore gives it exactly.
module n3by2_b2_divider (
  input  logic [2:0] d,
  input  logic [1:0] y,
  output logic       q,
  output logic [1:0] r
);
  assign q = (d >= {1'b0, y});
  assign r = d[1:0] - (q ? y : 2'b00);
endmodule

module n4by2_b2_div_sequencer #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] x_a,
  input  logic [1:0] y_a,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [3:0] x_b,
  input  logic [1:0] y_b,
  output logic       gnt_b,
  output logic       out_valid,
  output logic       out_id,
  output logic [1:0] q,
  output logic [1:0] r,
  output logic       no_div,
  input  logic       out_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STEP1 = 2'd1;
  localparam logic [1:0] STEP2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       ptr;        // 0: A wins next contention, 1: B wins
  logic [3:0] x_r;
  logic [1:0] y_r;
  logic       id_r;
  logic [1:0] pr_r;       // partial remainder between the two stage passes
  logic [1:0] q_r;
  logic [1:0] r_r;
  logic       nd_r;

  logic       idle_ok;
  logic       accept;
  logic [3:0] sel_x;
  logic [1:0] sel_y;
  logic       infeasible;
  logic [2:0] st_d;
  logic [1:0] st_y;
  logic       st_q;
  logic [1:0] st_r;

  // Arbitration: grants only from IDLE, and reset suppresses them outright.
  assign idle_ok = (state == IDLE) && !reset;
  assign gnt_a   = idle_ok && req_a && (!req_b || !ptr);
  assign gnt_b   = idle_ok && req_b && (!req_a ||  ptr);
  assign accept  = gnt_a || gnt_b;

  assign sel_x = gnt_b ? x_b : x_a;
  assign sel_y = gnt_b ? y_b : y_a;

  // Widened compare so 4*y is never truncated.
  assign infeasible = (sel_y == 2'd0) ||
                      ({1'b0, sel_x} >= {1'b0, sel_y, 2'b00});

  // Stage operand mux; inputs are don't-care (tied to 0) outside STEP1/STEP2.
  always_comb begin
    st_d = 3'd0;
    st_y = 2'd0;
    case (state)
      STEP1: begin
        st_d = x_r[3:1];
        st_y = y_r;
      end
      STEP2: begin
        st_d = {pr_r, x_r[0]};
        st_y = y_r;
      end
      default: ;
    endcase
  end

  n3by2_b2_divider u_stage (
    .d (st_d),
    .y (st_y),
    .q (st_q),
    .r (st_r)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= RR_INIT;
      x_r   <= 4'd0;
      y_r   <= 2'd0;
      id_r  <= 1'b0;
      pr_r  <= 2'd0;
      q_r   <= 2'd0;
      r_r   <= 2'd0;
      nd_r  <= 1'b0;
    end else begin
      case (state)
        // Accept: latch granted operands, hand priority to the other side.
        IDLE: begin
          if (accept) begin
            x_r  <= sel_x;
            y_r  <= sel_y;
            id_r <= gnt_b;
            ptr  <= gnt_a;
            q_r  <= 2'd0;
            r_r  <= 2'd0;
            nd_r <= infeasible;
            state <= infeasible ? DONE : STEP1;
          end
        end
        // First pass: upper three dividend digits.
        STEP1: begin
          q_r[1] <= st_q;
          pr_r   <= st_r;
          state  <= STEP2;
        end
        // Second pass: partial remainder with the last dividend digit.
        STEP2: begin
          q_r[0] <= st_q;
          r_r    <= st_r;
          state  <= DONE;
        end
        // Result held until acknowledged.
        default: begin
          if (out_ack) state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_id    = id_r;
  assign q         = q_r;
  assign r         = r_r;
  assign no_div    = nd_r;

endmodule
